// File: rtl/cte_pkg.sv
// Shared types and constants for the CTE YUV->RGB path.
//   phase_e  : position of the next byte in a U,Y0,V,Y1 group
//   K_*      : colour coefficients, round(c*256)
//   ROUND    : half-LSB added before the FRAC shift
//   clamp_u8 : saturate a shifted signed intermediate to 0..255
package cte_pkg;

    typedef enum logic [1:0] {
        P_U  = 2'd0,
        P_Y0 = 2'd1,
        P_V  = 2'd2,
        P_Y1 = 2'd3
    } phase_e;

    localparam int unsigned IW    = 19;
    localparam int unsigned PIX_W = 24;

    localparam logic signed [IW-1:0] K_RV  = IW'(359);
    localparam logic signed [IW-1:0] K_GU  = IW'(88);
    localparam logic signed [IW-1:0] K_GV  = IW'(183);
    localparam logic signed [IW-1:0] K_BU  = IW'(454);
    localparam logic signed [IW-1:0] ROUND = IW'(128);

    // Negative values saturate to 0, values above 255 to 255.
    function automatic logic [7:0] clamp_u8(input logic signed [IW-1:0] x);
        logic [7:0] res;
        if (x[IW-1])
            res = 8'd0;
        else if (x > IW'(255))
            res = 8'd255;
        else
            res = x[7:0];
        return res;
    endfunction

endpackage

// File: rtl/cte_pix_fifo.sv
// Pixel FIFO with a registered head.
//   clk, rst  : clock, asynchronous active-high reset
//   i_push    : write i_din this edge
//   i_ready   : consumer takes the head when o_valid is high
//   o_valid   : head register holds a pixel
//   o_dout    : head pixel; keeps the last popped value while empty
//   o_count   : pixels held (memory plus head register)
// A pushed pixel lands in memory first and reaches the head on the
// following edge, so an empty FIFO shows a new pixel one edge after push.
module cte_pix_fifo
    import cte_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [PIX_W-1:0]             i_din,
    input  logic                         i_ready,
    output logic                         o_valid,
    output logic [PIX_W-1:0]             o_dout,
    output logic [$clog2(DEPTH):0]       o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [PIX_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_mem_cnt;
    logic             r_valid;
    logic [PIX_W-1:0] r_dout;

    logic w_pop;
    logic w_load;

    assign w_pop  = r_valid & i_ready;
    // Refill the head whenever it is empty or being consumed this edge.
    assign w_load = (r_mem_cnt != '0) && (!r_valid || w_pop);

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr] <= i_din;
    end

    // Pointers, occupancy and head register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_mem_cnt <= '0;
            r_valid   <= 1'b0;
            r_dout    <= '0;
        end else begin
            if (i_push)
                r_wr <= r_wr + AW'(1);
            if (w_load) begin
                r_rd    <= r_rd + AW'(1);
                r_dout  <= r_mem[r_rd];
                r_valid <= 1'b1;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
            case ({i_push, w_load})
                2'b10:   r_mem_cnt <= r_mem_cnt + CW'(1);
                2'b01:   r_mem_cnt <= r_mem_cnt - CW'(1);
                default: r_mem_cnt <= r_mem_cnt;
            endcase
        end
    end

    assign o_valid = r_valid;
    assign o_dout  = r_dout;
    assign o_count = r_mem_cnt + CW'(r_valid);

endmodule

// File: rtl/cte_yuv2rgb.sv
// Inverse colour transform: 4:2:2 byte stream (U,Y0,V,Y1) to two RGB pixels.
//   clk, reset : clock, asynchronous active-high reset
//   in_en      : yuv_in valid this cycle
//   yuv_in     : stream byte (Y unsigned, U/V two's complement)
//   busy       : byte refused this cycle, source must hold it
//   out_ready  : downstream takes rgb_out
//   out_valid  : rgb_out holds a pixel
//   rgb_out    : {R,G,B}
// Stage 1 registers the products at the issuing accept edge, stage 2 sums,
// rounds and clamps into the pixel FIFO on the next edge.
module cte_yuv2rgb
    import cte_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned FRAC  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_en,
    input  logic [7:0]       yuv_in,
    output logic             busy,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [PIX_W-1:0] rgb_out
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = CW + 1;

    phase_e r_phase;
    phase_e w_phase_nxt;

    logic       w_accept;
    logic       w_issue;
    logic [7:0] r_u;
    logic [7:0] r_v;
    logic [7:0] r_y0;
    logic [7:0] w_y;
    logic [7:0] w_v;

    logic signed [IW-1:0] w_ysh;
    logic signed [IW-1:0] w_us;
    logic signed [IW-1:0] w_vs;

    logic                 r_s1_valid;
    logic signed [IW-1:0] r_s1_y;
    logic signed [IW-1:0] r_s1_rv;
    logic signed [IW-1:0] r_s1_gu;
    logic signed [IW-1:0] r_s1_gv;
    logic signed [IW-1:0] r_s1_bu;

    logic signed [IW-1:0] w_r_sum;
    logic signed [IW-1:0] w_g_sum;
    logic signed [IW-1:0] w_b_sum;
    logic signed [IW-1:0] w_r_sh;
    logic signed [IW-1:0] w_g_sh;
    logic signed [IW-1:0] w_b_sh;
    logic [PIX_W-1:0]     w_pix;

    logic [CW-1:0] w_count;
    logic [OW-1:0] w_occ;

    // Reserve room for the pixel in stage 1 so the FIFO can never overflow.
    assign w_occ    = OW'(w_count) + OW'(r_s1_valid);
    assign busy     = (w_occ >= OW'(DEPTH));
    assign w_accept = in_en & ~busy;
    assign w_issue  = w_accept && ((r_phase == P_V) || (r_phase == P_Y1));

    // Phase register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_phase <= P_U;
        else
            r_phase <= w_phase_nxt;
    end

    // Next phase: advance only on accept, wrapping after Y1.
    always_comb begin
        w_phase_nxt = r_phase;
        if (w_accept) begin
            case (r_phase)
                P_U:     w_phase_nxt = P_Y0;
                P_Y0:    w_phase_nxt = P_V;
                P_V:     w_phase_nxt = P_Y1;
                P_Y1:    w_phase_nxt = P_U;
                default: w_phase_nxt = P_U;
            endcase
        end
    end

    // Held chroma and first luma of the current group.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_u  <= '0;
            r_v  <= '0;
            r_y0 <= '0;
        end else if (w_accept) begin
            case (r_phase)
                P_U:     r_u  <= yuv_in;
                P_Y0:    r_y0 <= yuv_in;
                P_V:     r_v  <= yuv_in;
                default: ;
            endcase
        end
    end

    // Pixel0 uses V straight off the bus; pixel1 uses the held V.
    assign w_y   = (r_phase == P_V) ? r_y0 : yuv_in;
    assign w_v   = (r_phase == P_V) ? yuv_in : r_v;
    assign w_ysh = IW'(w_y) << FRAC;
    assign w_us  = IW'($signed(r_u));
    assign w_vs  = IW'($signed(w_v));

    // Stage 1: products.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_y     <= '0;
            r_s1_rv    <= '0;
            r_s1_gu    <= '0;
            r_s1_gv    <= '0;
            r_s1_bu    <= '0;
        end else begin
            r_s1_valid <= w_issue;
            if (w_issue) begin
                r_s1_y  <= w_ysh;
                r_s1_rv <= K_RV * w_vs;
                r_s1_gu <= K_GU * w_us;
                r_s1_gv <= K_GV * w_vs;
                r_s1_bu <= K_BU * w_us;
            end
        end
    end

    // Stage 2: sum, round, shift and clamp into the FIFO.
    assign w_r_sum = r_s1_y + r_s1_rv + ROUND;
    assign w_g_sum = r_s1_y - r_s1_gu - r_s1_gv + ROUND;
    assign w_b_sum = r_s1_y + r_s1_bu + ROUND;
    assign w_r_sh  = w_r_sum >>> FRAC;
    assign w_g_sh  = w_g_sum >>> FRAC;
    assign w_b_sh  = w_b_sum >>> FRAC;
    assign w_pix   = {clamp_u8(w_r_sh), clamp_u8(w_g_sh), clamp_u8(w_b_sh)};

    cte_pix_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (r_s1_valid),
        .i_din   (w_pix),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_dout  (rgb_out),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_cte_yuv2rgb.sv
// Self-checking bench for cte_yuv2rgb: vector table plus hand sequences,
// expected pixels queued on issue and compared as the DUT hands them out.
module tb_cte_yuv2rgb;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_en;
    logic [7:0]  yuv_in;
    logic        busy;
    logic        out_ready;
    logic        out_valid;
    logic [23:0] rgb_out;

    always #5 clk = ~clk;

    cte_yuv2rgb #(.DEPTH(4), .FRAC(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_en     (in_en),
        .yuv_in    (yuv_in),
        .busy      (busy),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .rgb_out   (rgb_out)
    );

    typedef struct {
        logic [7:0]  u;
        logic [7:0]  y0;
        logic [7:0]  v;
        logic [7:0]  y1;
        logic [23:0] e0;
        logic [23:0] e1;
    } vec_t;

    vec_t        tbl [6];
    logic [23:0] exp_q [$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_out = 0;
    bit          busy_seen = 0;
    bit          prev_hold = 0;
    logic [23:0] prev_rgb = '0;
    logic [23:0] last_pix = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference: straight integer evaluation of the colour equations.
    function automatic logic [7:0] sat(input int x);
        if (x < 0) return 8'd0;
        if (x > 255) return 8'd255;
        return 8'(x);
    endfunction

    function automatic logic [23:0] model(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
        int ys, us, vs, r, g, b;
        ys = int'(y);
        us = int'($signed(u));
        vs = int'($signed(v));
        r  = (ys * 256 + 359 * vs + 128) >>> 8;
        g  = (ys * 256 - 88 * us - 183 * vs + 128) >>> 8;
        b  = (ys * 256 + 454 * us + 128) >>> 8;
        return {sat(r), sat(g), sat(b)};
    endfunction

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 0;
        end else begin
            if (busy) busy_seen = 1;
            if (out_valid && !out_ready) begin
                if (prev_hold) chk("hold_stable", 32'(rgb_out), 32'(prev_rgb));
                prev_hold = 1;
                prev_rgb  = rgb_out;
            end else begin
                prev_hold = 0;
            end
            if (out_valid && out_ready) begin
                chk("pixel_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    last_pix = exp_q.pop_front();
                    chk("pixel", 32'(rgb_out), 32'(last_pix));
                end
                n_out++;
            end
        end
    end

    task automatic do_reset();
        in_en     = 1'b0;
        yuv_in    = 8'h00;
        out_ready = 1'b1;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        reset = 1'b0;
        n_out = 0;
    endtask

    // Present one byte and hold it until the DUT takes it.
    task automatic send(input logic [7:0] b);
        int t;
        bit acc;
        t   = 0;
        acc = 0;
        in_en  = 1'b1;
        yuv_in = b;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = !busy;
            @(posedge clk);
            t++;
        end
        #1;
        in_en = 1'b0;
        if (!acc) chk("accept_in_time", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_group(input vec_t g, input int gap);
        send(g.u);  idle(gap);
        send(g.y0); idle(gap);
        send(g.v);  exp_q.push_back(g.e0); idle(gap);
        send(g.y1); exp_q.push_back(g.e1);
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk(nm, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vec_t g;
        int   base;

        tbl[0] = '{u:8'h00, y0:8'h80, v:8'h00, y1:8'hFF, e0:24'h808080, e1:24'hFFFFFF};
        tbl[1] = '{u:8'h7F, y0:8'h80, v:8'h00, y1:8'h80, e0:24'h8054FF, e1:24'h8054FF};
        tbl[2] = '{u:8'h00, y0:8'h10, v:8'h80, y1:8'h10, e0:24'h006C10, e1:24'h006C10};
        for (int i = 3; i < 6; i++) begin
            tbl[i].u  = 8'($urandom);
            tbl[i].y0 = 8'($urandom);
            tbl[i].v  = 8'($urandom);
            tbl[i].y1 = 8'($urandom);
            tbl[i].e0 = model(tbl[i].y0, tbl[i].u, tbl[i].v);
            tbl[i].e1 = model(tbl[i].y1, tbl[i].u, tbl[i].v);
        end

        // Reset state.
        in_en = 1'b0; yuv_in = 8'h00; out_ready = 1'b1; reset = 1'b1;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_rgb", 32'(rgb_out), 32'd0);
        do_reset();

        // Latency of the first pixel after the V accept.
        send(8'h00);
        send(8'h80);
        send(8'h00);
        exp_q.push_back(24'h808080);
        @(negedge clk); chk("lat_edge0", 32'(out_valid), 32'd0);
        @(negedge clk); chk("lat_edge1", 32'(out_valid), 32'd0);
        @(negedge clk); chk("lat_edge2", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        send(8'hFF);
        exp_q.push_back(24'hFFFFFF);
        drain("drain_latency");

        // Table of groups, back to back.
        for (int i = 0; i < 6; i++) send_group(tbl[i], 0);
        drain("drain_table");
        idle(3);
        chk("empty_valid", 32'(out_valid), 32'd0);
        chk("empty_hold_rgb", 32'(rgb_out), 32'(tbl[5].e1));

        // Idle gaps between bytes do not advance the phase.
        send_group(tbl[0], 2);
        drain("drain_gaps");

        // Backpressure across three groups.
        out_ready = 1'b0;
        busy_seen = 0;
        base      = n_out;
        fork
            begin
                send_group(tbl[3], 0);
                send_group(tbl[4], 0);
                send_group(tbl[5], 0);
            end
            begin
                idle(20);
                chk("bp_busy_seen", 32'(busy_seen), 32'd1);
                chk("bp_busy_now", 32'(busy), 32'd1);
                chk("bp_no_output", 32'(n_out - base), 32'd0);
                out_ready = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("bp_burst_valid", 32'(out_valid), 32'd1);
                end
            end
        join
        drain("drain_bp");
        chk("bp_count", 32'(n_out - base), 32'd6);

        // Asynchronous reset in the middle of a group.
        out_ready = 1'b0;
        send_group(tbl[2], 0);
        idle(4);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        send(8'h00);
        send(8'h80);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_rgb", 32'(rgb_out), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        n_out = 0;
        g = tbl[1];
        send_group(g, 0);
        drain("drain_after_rst");
        idle(5);
        chk("after_rst_count", 32'(n_out), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
